// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, address width and parity/range helpers for the clearable RAM.
package mem_pkg;
    localparam int ADDR_W = 16;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    function automatic logic parity(input logic [63:0] d);
        return ^d;
    endfunction

    // Address bits above the implemented depth must all be zero.
    function automatic logic in_range(input logic [ADDR_W-1:0] a, input int unsigned dl2);
        return (a >> dl2) == '0;
    endfunction
endpackage

// File: rtl/ram_core.sv
// ram_core: bare storage array with one write port and a registered read port, no reset.
module ram_core #(
    parameter int W  = 16,
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic [AW-1:0] ra_i,
    output logic [W-1:0]  rd_o
);
    logic [W-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wa_i] <= wd_i;
        rd_o <= mem_q[ra_i];
    end
endmodule

// File: rtl/sdp_ram_clr.sv
// sdp_ram_clr: simple-dual-port RAM with clear sweep, write-first bypass and out-of-range detection.
// Optional per-word even parity when MEM_PARITY_EN is defined.
module sdp_ram_clr
    import mem_pkg::*;
#(
    parameter int              WIDTH      = 16,
    parameter int              DEPTH_LOG2 = 12,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              wren,
    input  logic [WIDTH-1:0]  data,
    input  logic              clr,
    input  logic              inj_perr,
    output logic [WIDTH-1:0]  q,
    output logic              oor,
    output logic              busy,
    output logic              perr
);
    localparam int AW = DEPTH_LOG2;
`ifdef MEM_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic             byp_q, byp_d, rd_vld_q, rd_vld_d, oor_q, oor_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;
    logic             run, wr_ok, rd_ok, we;
    logic [AW-1:0]    wa;
    logic [SW-1:0]    wd, rd_data;

    assign run   = state_q == ST_RUN;
    assign busy  = ~run;
    assign wr_ok = run & wren & in_range(wraddress, DEPTH_LOG2);
    assign rd_ok = run & in_range(rdaddress, DEPTH_LOG2);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (clr) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
        end else if (!run) begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            state_d   = &clr_ptr_q ? ST_RUN : ST_CLEAR;
        end
    end

    always_comb begin
        byp_d      = rd_ok & wr_ok & (rdaddress == wraddress);
        byp_data_d = data;
        rd_vld_d   = rd_ok & ~byp_d;
        oor_d      = run & ~in_range(rdaddress, DEPTH_LOG2);
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            rd_vld_q   <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            rd_vld_q   <= rd_vld_d;
            oor_q      <= oor_d;
        end
    end

    // The sweep owns the write port while clearing; user writes are dropped.
    assign we = ~run | wr_ok;
    assign wa = run ? wraddress[AW-1:0] : clr_ptr_q;

`ifdef MEM_PARITY_EN
    assign wd   = run ? {parity(64'(data)) ^ inj_perr, data}
                      : {parity(64'(INIT_VAL)), INIT_VAL};
    assign perr = rd_vld_q & (parity(64'(rd_data[WIDTH-1:0])) ^ rd_data[WIDTH]);
`else
    logic unused_inj;
    assign unused_inj = inj_perr;
    assign wd   = run ? data : INIT_VAL;
    assign perr = 1'b0;
`endif

    ram_core #(.W(SW), .AW(AW)) u_core (
        .clk_i (clock),
        .we_i  (we),
        .wa_i  (wa),
        .wd_i  (wd),
        .ra_i  (rdaddress[AW-1:0]),
        .rd_o  (rd_data)
    );

    assign q   = byp_q ? byp_data_q : (rd_vld_q ? rd_data[WIDTH-1:0] : '0);
    assign oor = oor_q;
endmodule

// File: tb/tb_sdp_ram_clr.sv
// tb_sdp_ram_clr: directed and randomized checks of sdp_ram_clr (DEPTH_LOG2=4, INIT_VAL=16'hA5A5) against a word-level model.
module tb_sdp_ram_clr;
`ifdef MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clock = 1'b0;
    logic        aclr = 1'b1;
    logic [15:0] wraddress = '0, rdaddress = '0, data = '0;
    logic        wren = 1'b0, clr = 1'b0, inj_perr = 1'b0;
    logic [15:0] q;
    logic        oor, busy, perr;

    int n_chk = 0, n_err = 0;
    bit chk_en = 1'b0;

    sdp_ram_clr #(.WIDTH(16), .DEPTH_LOG2(4), .INIT_VAL(INIT)) dut (
        .clock(clock), .aclr(aclr), .wraddress(wraddress), .rdaddress(rdaddress),
        .wren(wren), .data(data), .clr(clr), .inj_perr(inj_perr),
        .q(q), .oor(oor), .busy(busy), .perr(perr)
    );

    always #5 clock = ~clock;

    // Word-level model: rem counts remaining sweep cycles; the array is (re)filled when a sweep finishes.
    logic [15:0] mm [16];
    logic        mbad [16];
    int          rem;
    logic [15:0] eq;
    logic        eoor, eperr;

    always @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            rem <= 16; eq <= '0; eoor <= 1'b0; eperr <= 1'b0;
        end else begin
            if (rem == 0) begin
                if (rdaddress < 16) begin
                    eoor  <= 1'b0;
                    eq    <= (wren && wraddress == rdaddress) ? data : mm[rdaddress[3:0]];
                    eperr <= (wren && wraddress == rdaddress) ? 1'b0 : mbad[rdaddress[3:0]];
                end else begin
                    eq <= '0; eoor <= 1'b1; eperr <= 1'b0;
                end
                if (wren && wraddress < 16) begin
                    mm[wraddress[3:0]]   <= data;
                    mbad[wraddress[3:0]] <= PAR_EN & inj_perr;
                end
            end else begin
                eq <= '0; eoor <= 1'b0; eperr <= 1'b0;
                if (rem == 1)
                    for (int i = 0; i < 16; i++) begin mm[i] <= INIT; mbad[i] <= 1'b0; end
            end
            rem <= clr ? 16 : (rem == 0 ? 0 : rem - 1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model q", 32'(q), 32'(eq));
            chk("model oor", 32'(oor), 32'(eoor));
            chk("model busy", 32'(busy), 32'(rem != 0));
            chk("model perr", 32'(perr), 32'(eperr));
        end
    end

    task automatic drive(input logic we, input logic [15:0] wa, input logic [15:0] ra,
                         input logic [15:0] d, input logic c, input logic inj);
        wren = we; wraddress = wa; rdaddress = ra; data = d; clr = c; inj_perr = inj;
        @(negedge clock);
    endtask

    task automatic count_busy(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            drive(1'b1, 16'd3, 16'd0, 16'hFFFF, 1'b0, 1'b0);
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    initial begin
        #1 aclr = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        chk("reset q", 32'(q), 32'd0);
        chk("reset busy", 32'(busy), 32'd1);
        chk("reset oor/perr", 32'({oor, perr}), 32'd0);
        #2 aclr = 1'b1;
        count_busy("busy after reset");
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'd0, 16'(i), 16'd0, 1'b0, 1'b0);
            chk("init read", 32'(q), 32'(INIT));
        end
        drive(1'b1, 16'd5, 16'd0, 16'h1234, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 16'd5, 16'd0, 1'b0, 1'b0);
        chk("read after write", 32'(q), 32'h1234);
        drive(1'b1, 16'd7, 16'd7, 16'hBEEF, 1'b0, 1'b0);
        chk("bypass q", 32'(q), 32'hBEEF);
        drive(1'b1, 16'h0010, 16'd1, 16'h0001, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 16'h0010, 16'd0, 1'b0, 1'b0);
        chk("oor q", 32'(q), 32'd0);
        chk("oor flag", 32'(oor), 32'd1);
        drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        chk("in-range after oor", 32'({oor, q}), 32'(INIT));
`ifdef MEM_PARITY_EN
        drive(1'b1, 16'd2, 16'd0, 16'h00FF, 1'b0, 1'b1);
        drive(1'b0, 16'd0, 16'd2, 16'd0, 1'b0, 1'b0);
        chk("perr q", 32'(q), 32'h00FF);
        chk("perr set", 32'(perr), 32'd1);
        drive(1'b1, 16'd2, 16'd0, 16'h00FF, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 16'd2, 16'd0, 1'b0, 1'b0);
        chk("perr clear", 32'(perr), 32'd0);
`endif
        drive(1'b0, 16'd0, 16'd5, 16'd0, 1'b1, 1'b0);
        chk("clr access completes", 32'(q), 32'h1234);
        count_busy("busy after clr");
        drive(1'b0, 16'd0, 16'd3, 16'd0, 1'b0, 1'b0);
        chk("write during clear dropped", 32'(q), 32'(INIT));
        drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        #2 aclr = 1'b0;
        #1 chk("mid-sweep reset q", 32'(q), 32'd0);
        chk("mid-sweep reset busy", 32'(busy), 32'd1);
        @(negedge clock);
        #2 aclr = 1'b1;
        count_busy("busy after mid-sweep reset");
        drive(1'b0, 16'd0, 16'd5, 16'd0, 1'b0, 1'b0);
        chk("resweep contents", 32'(q), 32'(INIT));
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] wa, ra;
            wa = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa :
                 ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                #2 aclr = 1'b0;
                @(negedge clock);
                #2 aclr = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), wa, ra, 16'($urandom),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
